// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions.
// Opcodes, the reset nop and fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the retiring instruction.
// Jalr beats jump/branch, which beat the sequential pc+4.
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic            branch,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] instr_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic w_take;

  always_comb begin
    w_take = jump | (branch & branch_taken);
    if (jalr) begin
      next_pc = {alu_result[XLEN-1:1], 1'b0};
    end else if (w_take) begin
      next_pc = instr_pc + imm;
    end else begin
      next_pc = instr_pc + XLEN'(4);
    end
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake and
// the registered instruction handed to decode.
module fetch_unit #(
  parameter int                 XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  input  logic            instr_ack,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            fetch_fault
);

  import riscv_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_valid;
  logic            r_fault;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;
  logic            w_capture;
  logic            w_retire;

  next_pc_sel #(
    .XLEN (XLEN)
  ) u_next_pc_sel (
    .branch       (branch),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jalr         (jalr),
    .instr_pc     (r_instr_pc),
    .imm          (imm),
    .alu_result   (alu_result),
    .next_pc      (w_next_pc),
    .misaligned   (w_misaligned)
  );

  // S_REQ idles one cycle with the request low, so it leaves reset quiet.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (r_req) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = w_misaligned ? S_FAULT : S_REQ;
        end
      end
      default: w_state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_REQ);
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
        r_valid    <= 1'b1;
      end
      if (w_retire) begin
        r_pc    <= w_next_pc;
        r_valid <= 1'b0;
      end
      if (w_state_nxt == S_FAULT) r_fault <= 1'b1;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_plus4    = r_instr_pc + XLEN'(4);
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction model, memory
// responder and directed control-flow vectors.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack;
  logic        branch;
  logic        branch_taken;
  logic        jump;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        fetch_fault;

  int n_assert = 0;
  int n_fail   = 0;

  bit auto_mem = 1'b1;
  bit lat_rand = 1'b0;
  int man_cnt  = 0;
  logic [31:0] man_data = '0;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .instr_ack    (instr_ack),
    .branch       (branch),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jalr         (jalr),
    .imm          (imm),
    .alu_result   (alu_result),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[24:0], 7'h13};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: drives 2ns after the edge
  initial begin
    int          cnt;
    bit          pend;
    int          man_done;
    logic [31:0] a;
    cnt = 0; pend = 0; man_done = 0; a = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (man_cnt != man_done) begin
        man_done++;
        imem_rvalid = 1'b1;
        imem_rdata  = man_data;
      end
      if (rst || !auto_mem) begin
        pend = 0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(a);
            pend = 0;
          end
        end
        if (imem_req) begin
          pend = 1;
          a    = imem_addr;
          cnt  = lat_rand ? int'($urandom_range(1, 8)) : 1;
        end
      end
    end
  end

  // Transaction model: what each output must be, per cycle
  int          cyc      = 0;
  int          m_req_at = -100;
  bit          m_live   = 0;
  bit          m_out    = 0;
  bit          m_valid  = 0;
  bit          m_fault  = 0;
  logic [31:0] m_pc     = '0;
  logic [31:0] m_instr  = '0;
  logic [31:0] m_ipc    = '0;

  initial begin
    logic [31:0] nxt;
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("m_req",   {31'b0, imem_req}, {31'b0, cyc == m_req_at});
        chk("m_addr",  imem_addr, m_pc);
        chk("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("m_instr", instr, m_instr);
        chk("m_ipc",   instr_pc, m_ipc);
        chk("m_pc4",   pc_plus4, m_ipc + 32'd4);
        chk("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      end
      if (rst) begin
        m_live   = 1;
        m_pc     = 32'h0;
        m_valid  = 0;
        m_out    = 0;
        m_fault  = 0;
        m_instr  = 32'h0000_0013;
        m_ipc    = 32'h0;
        m_req_at = cyc + 2;
      end else if (m_live) begin
        if (m_out && imem_rvalid) begin
          m_out   = 0;
          m_valid = 1;
          m_instr = imem_rdata;
          m_ipc   = m_pc;
        end else if (m_valid && instr_ack) begin
          if (jalr)
            nxt = alu_result & ~32'd1;
          else if (jump || (branch && branch_taken))
            nxt = m_ipc + imm;
          else
            nxt = m_ipc + 32'd4;
          m_pc    = nxt;
          m_valid = 0;
          if (nxt[1:0] != 2'b00) begin
            m_fault  = 1;
            m_req_at = -100;
          end else begin
            m_req_at = cyc + 1;
          end
        end
        if (cyc == m_req_at) m_out = 1;
      end
      cyc++;
    end
  end

  task automatic wait_req(input logic [31:0] exp, input string nm);
    bit got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = imem_req;
    end
    chk({nm, "_req"}, {31'b0, imem_req}, 32'd1);
    chk({nm, "_addr"}, imem_addr, exp);
  endtask

  task automatic wait_valid(input string nm);
    bit got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = instr_valid;
    end
    chk({nm, "_valid"}, {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic retire(input logic br, input logic tk, input logic jp,
                        input logic jr, input logic [31:0] im,
                        input logic [31:0] al, input string nm);
    wait_valid(nm);
    @(posedge clk); #1;
    instr_ack = 1'b1; branch = br; branch_taken = tk;
    jump = jp; jalr = jr; imm = im; alu_result = al;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    branch = 1'($urandom); branch_taken = 1'($urandom);
    jump = 1'($urandom); jalr = 1'($urandom);
    imm = $urandom; alu_result = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int nreq;
    rst = 1'b1; instr_ack = 1'b0;
    branch = 0; branch_taken = 0; jump = 0; jalr = 0;
    imm = '0; alu_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_ipc",   instr_pc, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1) first fetch timing and sequential ack
    @(negedge clk);
    chk("t1_c0_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("t1_c1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_c1_addr", imem_addr, 32'h0);
    wait_valid("t1");
    chk("t1_instr", instr, memf(32'h0));
    retire(0, 0, 0, 0, 32'h0, 32'h0, "t1r");
    wait_req(32'h4, "t1_next");

    // 2) random latency, ack held high
    do_reset();
    lat_rand = 1'b1;
    @(posedge clk); #1;
    branch = 0; branch_taken = 0; jump = 0; jalr = 0;
    instr_ack = 1'b1;
    for (int i = 0; i < 12; i++) wait_valid("t2");
    @(posedge clk); #1;
    instr_ack = 1'b0;
    wait_req(32'h30, "t2_next");
    lat_rand = 1'b0;

    // 3) branches around 0x20
    do_reset();
    retire(0, 0, 1, 0, 32'h20, 32'h0, "t3_jmp");
    wait_req(32'h20, "t3_at20");
    retire(1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, "t3_bt");
    wait_req(32'h18, "t3_taken");
    retire(0, 1, 0, 0, 32'h40, 32'h0, "t3_s1");
    retire(0, 0, 0, 0, 32'h40, 32'h0, "t3_s2");
    wait_req(32'h20, "t3_back20");
    retire(1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, "t3_bnt");
    wait_req(32'h24, "t3_ntaken");

    // 4) jalr to odd-halfword target faults
    retire(0, 0, 1, 1, 32'h40, 32'h103, "t4_jalr");
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) nreq++;
    end
    chk("t4_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t4_nreq", nreq, 32'd0);
    chk("t4_addr", imem_addr, 32'h102);

    // 5) reset in S_WAIT, late rvalid dropped
    auto_mem = 1'b0;
    do_reset();
    chk("t5_fault_clr", {31'b0, fetch_fault}, 32'd0);
    wait_req(32'h0, "t5_first");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    man_data = 32'hDEAD_BEEF;
    man_cnt++;
    wait_req(32'h0, "t5_again");
    @(posedge clk); #1;
    man_data = 32'h00A0_0093;
    man_cnt++;
    wait_valid("t5");
    chk("t5_instr", instr, 32'h00A0_0093);
    chk("t5_ipc", instr_pc, 32'h0);
    auto_mem = 1'b1;

    // 6) wrap at top of memory
    do_reset();
    retire(0, 0, 1, 1, 32'h0, 32'hFFFF_FFFC, "t6_jalr");
    wait_req(32'hFFFF_FFFC, "t6_top");
    wait_valid("t6");
    chk("t6_pc4", pc_plus4, 32'h0);
    retire(0, 0, 0, 0, 32'h0, 32'h0, "t6_seq");
    wait_req(32'h0, "t6_wrap");
    chk("t6_nofault", {31'b0, fetch_fault}, 32'd0);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
